// File: rtl/detector_scheduler.sv
// detector_scheduler: round-robin shares one serial Mealy detector between two word requesters
module detector_scheduler #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             det_x,
   output logic             det_rst_n,
   input  logic             det_y,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [CNTW-1:0]  hit_count
);
   localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0] bit_cnt;
   logic [CNTW-1:0] cnt, cnt_inc;
   logic last_grant, id, pick1;
   assign pick1 = req1 & (~req0 | ~last_grant);
   assign cnt_inc = (det_y && cnt != '1) ? cnt + CNTW'(1) : cnt;
   always_comb begin
      state_nx = state;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            gnt1 = pick1;
            gnt0 = req0 & ~pick1;
            if (req0 | req1) state_nx = CLEAR;
         end
         CLEAR:  state_nx = SHIFT;
         SHIFT:  if (bit_cnt == '0) state_nx = REPORT;
         REPORT: state_nx = IDLE;
      endcase
      busy  = state != IDLE;
      done  = state == REPORT;
      det_x = state == SHIFT && sr[WIDTH-1];
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id         <= 1'b0;
         sr         <= '0;
         bit_cnt    <= '0;
         cnt        <= '0;
         hit_count  <= '0;
         done_id    <= 1'b0;
         det_rst_n  <= 1'b0;
      end else begin
         state     <= state_nx;
         det_rst_n <= state_nx != CLEAR;
         case (state)
            IDLE: if (gnt0 | gnt1) begin
               sr         <= gnt1 ? data1 : data0;
               last_grant <= gnt1;
               id         <= gnt1;
            end
            CLEAR: begin
               cnt     <= '0;
               bit_cnt <= BW'(WIDTH - 1);
            end
            SHIFT: begin
               cnt     <= cnt_inc;
               sr      <= sr << 1;
               bit_cnt <= bit_cnt - BW'(1);
               if (bit_cnt == '0) begin
                  hit_count <= cnt_inc;
                  done_id   <= id;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_detector_scheduler.sv
// tb_detector_scheduler: directed vector bench with a behavioural model of the shared detector
module tb_detector_scheduler;
   logic clock, reset;
   logic req0, req1, gnt0, gnt1, det_x, det_rst_n, det_y, busy, done, done_id;
   logic [7:0] data0, data1;
   logic [3:0] hit_count;
   logic s_req0, s_gnt0, s_gnt1, s_det_x, s_det_rst_n, s_det_y, s_busy, s_done, s_done_id;
   logic [7:0] s_data0;
   logic [1:0] s_hit;
   logic [1:0] ds, s_ds;
   int n_vec = 0, n_bad = 0, cyc = 0;

   detector_scheduler u_dut (
      .clock(clock), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .det_x(det_x), .det_rst_n(det_rst_n), .det_y(det_y),
      .busy(busy), .done(done), .done_id(done_id), .hit_count(hit_count));

   detector_scheduler #(.WIDTH(8), .CNTW(2)) u_sat (
      .clock(clock), .reset(reset), .req0(s_req0), .data0(s_data0), .req1(1'b0), .data1(8'h00),
      .gnt0(s_gnt0), .gnt1(s_gnt1), .det_x(s_det_x), .det_rst_n(s_det_rst_n), .det_y(s_det_y),
      .busy(s_busy), .done(s_done), .done_id(s_done_id), .hit_count(s_hit));

   // Detector: S0 -1-> S1 -1-> S2 -1-> S3 (sticky); a 0 in S1/S2 falls back to S0
   function automatic logic [1:0] det_nxt(input logic [1:0] s, input logic x);
      return s == 2'd3 ? 2'd3 : x ? s + 2'd1 : 2'd0;
   endfunction
   always @(posedge clock or negedge det_rst_n)
      if (!det_rst_n) ds <= 2'd0;
      else ds <= det_nxt(ds, det_x);
   always @(posedge clock or negedge s_det_rst_n)
      if (!s_det_rst_n) s_ds <= 2'd0;
      else s_ds <= det_nxt(s_ds, s_det_x);
   assign det_y = ds != 2'd0 && !det_x;
   assign s_det_y = s_ds != 2'd0 && !s_det_x;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_gnt();
      int k = 0;
      #1;
      while (!(gnt0 || gnt1) && k < 30) begin
         tick();
         k++;
      end
   endtask

   task automatic do_word(input string nm, input logic r0, input logic [7:0] d0,
                          input logic r1, input logic [7:0] d1, input logic eid, input logic [3:0] ehits);
      int lat;
      logic [7:0] xs, w;
      req0 = r0; data0 = d0; req1 = r1; data1 = d1;
      wait_gnt();
      chk({nm, " grant seen"}, 32'(gnt0 | gnt1), 1);
      chk({nm, " grant id"}, 32'({gnt1, gnt0}), eid ? 2 : 1);
      w = gnt1 ? d1 : d0;
      tick();
      req0 = 0; req1 = 0;
      chk({nm, " clear rst_n/busy"}, 32'({det_rst_n, busy}), 1);
      lat = 1; xs = 0;
      while (!done && lat < 30) begin
         tick();
         lat++;
         if (lat >= 2 && lat <= 9) xs = {xs[6:0], det_x};
      end
      chk({nm, " done latency"}, 32'(lat), 10);
      chk({nm, " hit_count"}, 32'(hit_count), 32'(ehits));
      chk({nm, " done_id"}, 32'(done_id), 32'(eid));
      chk({nm, " det_x seq"}, 32'(xs), 32'(w));
   endtask

   typedef struct {
      logic r0; logic [7:0] d0; logic r1; logic [7:0] d1; logic id; logic [3:0] hits;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int k, last_done, bad;
      tbl[0] = '{1, 8'hA0, 0, 8'h00, 0, 4'd2};
      tbl[1] = '{0, 8'h00, 1, 8'hFF, 1, 4'd0};
      tbl[2] = '{1, 8'hE0, 0, 8'h00, 0, 4'd5};
      tbl[3] = '{0, 8'h00, 1, 8'h00, 1, 4'd0};
      tbl[4] = '{1, 8'hE0, 1, 8'h00, 0, 4'd5};
      tbl[5] = '{1, 8'hA0, 1, 8'hFF, 1, 4'd0};
      tbl[6] = '{0, 8'h00, 1, 8'hA0, 1, 4'd2};
      tbl[7] = '{1, 8'h5A, 0, 8'h00, 0, 4'd3};
      reset = 1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; s_req0 = 0; s_data0 = 0;
      tick(); tick();
      chk("reset busy/done", 32'({busy, done}), 0);
      chk("reset det_x/rst_n", 32'({det_x, det_rst_n}), 0);
      chk("reset done_id", 32'(done_id), 0);
      chk("reset hit_count", 32'(hit_count), 0);
      chk("reset gnt", 32'({gnt1, gnt0}), 0);
      reset = 0;
      for (int i = 0; i < 8; i++)
         do_word($sformatf("vec%0d", i), tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].id, tbl[i].hits);
      tick();
      req0 = 1; data0 = 8'hE0;
      wait_gnt();
      chk("abort grant", 32'(gnt0), 1);
      for (int i = 0; i < 5; i++) tick();
      req0 = 0;
      chk("abort in shift", 32'({busy, done}), 2);
      reset = 1;
      #1;
      chk("abort busy/done", 32'({busy, done}), 0);
      chk("abort det_x/rst_n", 32'({det_x, det_rst_n}), 0);
      chk("abort hit/id", 32'({hit_count, done_id}), 0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done || busy) bad = 1;
      end
      chk("abort quiet", 32'(bad), 0);
      reset = 0;
      req0 = 1; req1 = 1; data0 = 8'hE0; data1 = 8'h00;
      last_done = 0;
      for (int i = 0; i < 4; i++) begin
         wait_gnt();
         chk($sformatf("alt%0d grant", i), 32'({gnt1, gnt0}), (i % 2) ? 2 : 1);
         k = 0;
         do begin tick(); k++; end while (!done && k < 30);
         chk($sformatf("alt%0d done seen", i), 32'(done), 1);
         chk($sformatf("alt%0d done_id", i), 32'(done_id), 32'(i % 2));
         chk($sformatf("alt%0d hit_count", i), 32'(hit_count), (i % 2) ? 0 : 5);
         if (i > 0) chk($sformatf("alt%0d spacing", i), 32'(cyc - last_done), 11);
         last_done = cyc;
         if (i == 3) begin req0 = 0; req1 = 0; end
         tick();
      end
      req0 = 1; data0 = 8'h80;
      wait_gnt();
      chk("busy first grant", 32'({gnt1, gnt0}), 1);
      tick();
      req0 = 0;
      tick();
      req1 = 1; data1 = 8'hA0;
      #1;
      bad = (gnt0 || gnt1) ? 1 : 0;
      k = 0;
      while (!done && k < 30) begin
         tick();
         k++;
         if (!done && (gnt0 || gnt1)) bad = 1;
      end
      chk("busy gnt blocked", 32'(bad), 0);
      chk("busy first result", 32'({done, done_id, hit_count}), 32'({1'b1, 1'b0, 4'd1}));
      tick();
      chk("busy late grant", 32'({gnt1, gnt0}), 2);
      tick();
      req1 = 0;
      bad = 0; k = 0;
      while (!done && k < 30) begin
         if (hit_count != 4'd1) bad = 1;
         tick();
         k++;
      end
      chk("busy hit held", 32'(bad), 0);
      chk("busy second result", 32'({done, done_id, hit_count}), 32'({1'b1, 1'b1, 4'd2}));
      s_req0 = 1; s_data0 = 8'hE0;
      k = 0;
      #1;
      while (!s_gnt0 && k < 30) begin tick(); k++; end
      chk("sat grant", 32'(s_gnt0), 1);
      tick();
      s_req0 = 0;
      k = 0;
      while (!s_done && k < 30) begin tick(); k++; end
      chk("sat done seen", 32'(s_done), 1);
      chk("sat hit_count", 32'(s_hit), 3);
      chk("sat done_id", 32'(s_done_id), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
